// File: rtl/sat_pkg.sv
// Shared types and literal helpers for the DPLL solver tile.
package sat_pkg;

    // Widest literal the helpers accept; instances narrow via the lw argument.
    localparam int unsigned MAX_LIT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECIDE    = 3'd1,
        ST_SCAN      = 3'd2,
        ST_BACKTRACK = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_SAT   = 2'd1,
        RES_UNSAT = 2'd2,
        RES_LIMIT = 2'd3
    } result_t;

    // Variable index held in the low lw-1 bits of a literal.
    function automatic int unsigned lit_var(input logic [MAX_LIT_W-1:0] lit,
                                            input int unsigned lw);
        logic [MAX_LIT_W-1:0] mask;
        mask = (MAX_LIT_W'(1) << (lw - 1)) - MAX_LIT_W'(1);
        return 32'(lit & mask);
    endfunction

    // Negate flag held in the top bit of a literal.
    function automatic logic lit_neg(input logic [MAX_LIT_W-1:0] lit,
                                     input int unsigned lw);
        logic [MAX_LIT_W-1:0] sh;
        sh = lit >> (lw - 1);
        return sh[0];
    endfunction

    // Index 0 or beyond the variable count marks an unused slot.
    function automatic logic lit_is_pad(input int unsigned v, input int unsigned nv);
        return (v == 0) || (v > nv);
    endfunction

endpackage

// File: rtl/sat_clause_eval.sv
// Combinational falsification check of one clause row.
module sat_clause_eval
    import sat_pkg::*;
#(
    parameter int unsigned COLS_PER_ROW = 4,
    parameter int unsigned LIT_WIDTH    = 6,
    parameter int unsigned NUM_VARS     = 8
) (
    input  logic [COLS_PER_ROW*LIT_WIDTH-1:0] row,
    input  logic [NUM_VARS:1]                 assigned,
    input  logic [NUM_VARS:1]                 values,
    output logic                              falsified_c
);

    localparam int unsigned VW = $clog2(NUM_VARS + 1);

    logic any_real;
    logic all_false;

    // Row is falsified when it has a real literal and every real literal is assigned false.
    always_comb begin
        any_real  = 1'b0;
        all_false = 1'b1;
        for (int s = 0; s < int'(COLS_PER_ROW); s++) begin
            logic [MAX_LIT_W-1:0] lit;
            int unsigned          v;
            logic                 n;
            lit = MAX_LIT_W'(row[s*LIT_WIDTH +: LIT_WIDTH]);
            v   = lit_var(lit, LIT_WIDTH);
            n   = lit_neg(lit, LIT_WIDTH);
            if (!lit_is_pad(v, NUM_VARS)) begin
                any_real = 1'b1;
                if (!(assigned[VW'(v)] && (values[VW'(v)] == n))) begin
                    all_false = 1'b0;
                end
            end
        end
        falsified_c = any_real && all_false;
    end

endmodule

// File: rtl/sat_dpll_node.sv
// One DPLL solver tile: clause memory, chronological backtracking search, conflict budget.
module sat_dpll_node
    import sat_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES  = 16,
    parameter int unsigned COLS_PER_ROW = 4,
    parameter int unsigned NUM_VARS     = 8,
    parameter int unsigned LIT_WIDTH    = 6,
    parameter string       INIT_FILE    = "",
    parameter int unsigned CNT_W        = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 cfg_we,
    input  logic [$clog2(NUM_CLAUSES)-1:0]       cfg_addr,
    input  logic [COLS_PER_ROW*LIT_WIDTH-1:0]    cfg_wdata,
    input  logic [$clog2(NUM_CLAUSES+1)-1:0]     num_clauses,
    input  logic [CNT_W-1:0]                     conflict_limit,
    output logic                                 done,
    output logic                                 result_sat,
    output logic [1:0]                           result_code,
    output logic [NUM_VARS:1]                    assigned,
    output logic [NUM_VARS:1]                    values,
    output logic [CNT_W-1:0]                     cycle_count,
    output logic [CNT_W-1:0]                     conflict_count,
    output logic [2:0]                           state_out
);

    localparam int unsigned AW  = $clog2(NUM_CLAUSES);
    localparam int unsigned NCW = $clog2(NUM_CLAUSES + 1);
    localparam int unsigned RW  = COLS_PER_ROW * LIT_WIDTH;
    localparam int unsigned VW  = $clog2(NUM_VARS + 1);
    localparam int unsigned SPW = $clog2(NUM_VARS + 1);
    localparam int unsigned TW  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

    // Clause storage; contents survive reset and are written only by the host.
    logic [RW-1:0] mem [NUM_CLAUSES];

    state_t               state_q, state_d;
    result_t              result_q, result_d;
    logic [NUM_VARS:1]    assigned_q, assigned_d;
    logic [NUM_VARS:1]    values_q, values_d;
    logic [VW-1:0]        trail_var_q [NUM_VARS];
    logic [VW-1:0]        trail_var_d [NUM_VARS];
    logic [NUM_VARS-1:0]  trail_flip_q, trail_flip_d;
    logic [SPW-1:0]       sp_q, sp_d;
    logic [AW-1:0]        row_q, row_d;
    logic [NCW-1:0]       nc_q, nc_d;
    logic [CNT_W-1:0]     limit_q, limit_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     conf_q, conf_d;
    logic                 done_q;
    logic                 result_sat_q;

    logic                 active;
    logic                 row_fals_c;
    logic                 row_in_range;
    logic                 row_last;
    logic [TW-1:0]        top_idx;
    logic [VW-1:0]        top_var;
    logic [VW-1:0]        pick_var;
    logic                 pick_found;

    // Host row writes, accepted only while the engine is parked.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == ST_IDLE || state_q == ST_DONE)
            && (32'(cfg_addr) < NUM_CLAUSES)) begin
            mem[cfg_addr] <= cfg_wdata;
        end
    end

    sat_clause_eval #(
        .COLS_PER_ROW (COLS_PER_ROW),
        .LIT_WIDTH    (LIT_WIDTH),
        .NUM_VARS     (NUM_VARS)
    ) u_eval (
        .row         (mem[row_q]),
        .assigned    (assigned_q),
        .values      (values_q),
        .falsified_c (row_fals_c)
    );

    assign active       = (state_q == ST_DECIDE) || (state_q == ST_SCAN) || (state_q == ST_BACKTRACK);
    assign row_in_range = 32'(row_q) < 32'(nc_q);
    assign row_last     = (32'(row_q) + 32'd1) >= 32'(nc_q);
    assign top_idx      = TW'(sp_q - SPW'(1));
    assign top_var      = trail_var_q[top_idx];

    // Lowest-numbered unassigned variable for the next decision.
    always_comb begin
        pick_var   = '0;
        pick_found = 1'b0;
        for (int i = int'(NUM_VARS); i >= 1; i--) begin
            if (!assigned_q[VW'(i)]) begin
                pick_var   = VW'(i);
                pick_found = 1'b1;
            end
        end
    end

    // Next-state and datapath updates for the search engine.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        assigned_d   = assigned_q;
        values_d     = values_q;
        trail_var_d  = trail_var_q;
        trail_flip_d = trail_flip_q;
        sp_d         = sp_q;
        row_d        = row_q;
        nc_d         = nc_q;
        limit_d      = limit_q;
        cycle_d      = cycle_q;
        conf_d       = conf_q;

        if (active) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        if (active && abort) begin
            state_d    = ST_IDLE;
            result_d   = RES_NONE;
            assigned_d = '0;
            sp_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        assigned_d   = '0;
                        values_d     = '0;
                        cycle_d      = '0;
                        conf_d       = '0;
                        sp_d         = '0;
                        trail_flip_d = '0;
                        row_d        = '0;
                        result_d     = RES_NONE;
                        limit_d      = conflict_limit;
                        nc_d         = (32'(num_clauses) > NUM_CLAUSES) ? NCW'(NUM_CLAUSES) : num_clauses;
                        state_d      = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (pick_found) begin
                        assigned_d[pick_var]         = 1'b1;
                        values_d[pick_var]           = 1'b0;
                        trail_var_d[TW'(sp_q)]       = pick_var;
                        trail_flip_d[TW'(sp_q)]      = 1'b0;
                        sp_d                         = sp_q + SPW'(1);
                        row_d                        = '0;
                        state_d                      = ST_SCAN;
                    end else begin
                        result_d = RES_SAT;
                        state_d  = ST_DONE;
                    end
                end
                ST_SCAN: begin
                    if (row_fals_c && row_in_range) begin
                        conf_d = conf_q + CNT_W'(1);
                        if ((limit_q != '0) && (conf_d == limit_q)) begin
                            result_d = RES_LIMIT;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_BACKTRACK;
                        end
                    end else if (row_last) begin
                        if (&assigned_q) begin
                            result_d = RES_SAT;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_DECIDE;
                        end
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end
                ST_BACKTRACK: begin
                    if (sp_q == '0) begin
                        result_d = RES_UNSAT;
                        state_d  = ST_DONE;
                    end else if (trail_flip_q[top_idx]) begin
                        assigned_d[top_var] = 1'b0;
                        values_d[top_var]   = 1'b0;
                        sp_d                = sp_q - SPW'(1);
                    end else begin
                        values_d[top_var]     = 1'b1;
                        trail_flip_d[top_idx] = 1'b1;
                        row_d                 = '0;
                        state_d               = ST_SCAN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            result_q     <= RES_NONE;
            assigned_q   <= '0;
            values_q     <= '0;
            for (int i = 0; i < int'(NUM_VARS); i++) begin
                trail_var_q[i] <= '0;
            end
            trail_flip_q <= '0;
            sp_q         <= '0;
            row_q        <= '0;
            nc_q         <= '0;
            limit_q      <= '0;
            cycle_q      <= '0;
            conf_q       <= '0;
            done_q       <= 1'b0;
            result_sat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            assigned_q   <= assigned_d;
            values_q     <= values_d;
            trail_var_q  <= trail_var_d;
            trail_flip_q <= trail_flip_d;
            sp_q         <= sp_d;
            row_q        <= row_d;
            nc_q         <= nc_d;
            limit_q      <= limit_d;
            cycle_q      <= cycle_d;
            conf_q       <= conf_d;
            done_q       <= (state_d == ST_DONE);
            result_sat_q <= (result_d == RES_SAT);
        end
    end

    assign done           = done_q;
    assign result_sat     = result_sat_q;
    assign result_code    = result_q;
    assign assigned       = assigned_q;
    assign values         = values_q;
    assign cycle_count    = cycle_q;
    assign conflict_count = conf_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_sat_dpll_node.sv
// Directed self-checking bench for sat_dpll_node (3-variable and 1-variable tiles).
module tb_sat_dpll_node;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic        abort;
    logic        cfg_we_a, cfg_we_b;
    logic [3:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic [4:0]  num_clauses;
    logic [31:0] conflict_limit;

    logic        done_a, done_b;
    logic        rsat_a, rsat_b;
    logic [1:0]  rc_a, rc_b;
    logic [3:1]  asg_a, val_a;
    logic [1:1]  asg_b, val_b;
    logic [31:0] cyc_a, cyc_b, conf_a, conf_b;
    logic [2:0]  st_a, st_b;

    int passed = 0;
    int total  = 0;

    sat_dpll_node #(.NUM_VARS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .cfg_we(cfg_we_a), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .num_clauses(num_clauses), .conflict_limit(conflict_limit),
        .done(done_a), .result_sat(rsat_a), .result_code(rc_a),
        .assigned(asg_a), .values(val_a), .cycle_count(cyc_a),
        .conflict_count(conf_a), .state_out(st_a)
    );

    sat_dpll_node #(.NUM_VARS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .cfg_we(cfg_we_b), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .num_clauses(num_clauses), .conflict_limit(conflict_limit),
        .done(done_b), .result_sat(rsat_b), .result_code(rc_b),
        .assigned(asg_b), .values(val_b), .cycle_count(cyc_b),
        .conflict_count(conf_b), .state_out(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk_row(input logic [5:0] l0, input logic [5:0] l1);
        return {12'd0, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input bit sel, input int addr, input logic [23:0] d);
        @(negedge clk);
        cfg_addr  = 4'(addr);
        cfg_wdata = d;
        if (sel) cfg_we_b = 1'b1; else cfg_we_a = 1'b1;
        @(negedge clk);
        cfg_we_a = 1'b0;
        cfg_we_b = 1'b0;
    endtask

    task automatic load_t1();
        wr(1'b0, 0, mk_row(6'h01, 6'h02));   // x1 | x2
        wr(1'b0, 1, mk_row(6'h21, 6'h03));   // ~x1 | x3
        wr(1'b0, 2, mk_row(6'h22, 6'h23));   // ~x2 | ~x3
    endtask

    task automatic run(input bit sel, input int nc, input int lim, input string tag);
        @(negedge clk);
        num_clauses    = 5'(nc);
        conflict_limit = 32'(lim);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ((sel ? done_b : done_a) === 1'b1) break;
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(sel ? done_b : done_a), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        cfg_we_a = 1'b0; cfg_we_b = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        num_clauses = '0; conflict_limit = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset values
        chk("rst_state", 32'(st_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_code", 32'(rc_a), 32'd0);
        chk("rst_assigned", 32'(asg_a), 32'd0);
        chk("rst_cycles", cyc_a, 32'd0);

        load_t1();
        wr(1'b1, 0, mk_row(6'h01, 6'h00));   // x1
        wr(1'b1, 1, mk_row(6'h21, 6'h00));   // ~x1

        // 1: satisfiable with one conflict
        run(1'b0, 3, 0, "t1");
        chk("t1_code", 32'(rc_a), 32'd1);
        chk("t1_sat", 32'(rsat_a), 32'd1);
        chk("t1_values", 32'(val_a), 32'h2);
        chk("t1_assigned", 32'(asg_a), 32'h7);
        chk("t1_cycles", cyc_a, 32'd14);
        chk("t1_conflicts", conf_a, 32'd1);

        // 2: unsatisfiable
        run(1'b1, 2, 0, "t2");
        chk("t2_code", 32'(rc_b), 32'd2);
        chk("t2_sat", 32'(rsat_b), 32'd0);
        chk("t2_assigned", 32'(asg_b), 32'd0);
        chk("t2_cycles", cyc_b, 32'd7);
        chk("t2_conflicts", conf_b, 32'd2);

        // 3: conflict budget of one
        run(1'b1, 2, 1, "t3");
        chk("t3_code", 32'(rc_b), 32'd3);
        chk("t3_cycles", cyc_b, 32'd2);
        chk("t3_conflicts", conf_b, 32'd1);
        chk("t3_assigned", 32'(asg_b), 32'd1);
        chk("t3_values", 32'(val_b), 32'd0);

        // 4a: no active clauses
        run(1'b0, 0, 0, "t4a");
        chk("t4a_code", 32'(rc_a), 32'd1);
        chk("t4a_values", 32'(val_a), 32'd0);
        chk("t4a_cycles", cyc_a, 32'd6);

        // 4b: padding-only rows (index 0, index beyond NUM_VARS, negated padding)
        wr(1'b0, 0, mk_row(6'h05, 6'h27));
        wr(1'b0, 1, mk_row(6'h00, 6'h00));
        run(1'b0, 2, 0, "t4b");
        chk("t4b_code", 32'(rc_a), 32'd1);
        chk("t4b_values", 32'(val_a), 32'd0);
        chk("t4b_cycles", cyc_a, 32'd9);
        load_t1();

        // 5: abort mid-scan, with a write attempted while busy
        @(negedge clk);
        num_clauses = 5'd3; conflict_limit = '0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cfg_we_a = 1'b1; cfg_addr = 4'd0; cfg_wdata = mk_row(6'h21, 6'h00);
        @(negedge clk);
        cfg_we_a = 1'b0;
        chk("t5_in_scan", 32'(st_a), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_state", 32'(st_a), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_code", 32'(rc_a), 32'd0);
        chk("t5_assigned", 32'(asg_a), 32'd0);
        chk("t5_cycles_held", cyc_a, 32'd2);
        run(1'b0, 3, 0, "t5r");
        chk("t5r_code", 32'(rc_a), 32'd1);
        chk("t5r_values", 32'(val_a), 32'h2);
        chk("t5r_cycles", cyc_a, 32'd14);

        // 6: asynchronous reset while backtracking
        @(negedge clk);
        num_clauses = 5'd3; conflict_limit = '0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (st_a === 3'd3) break;
            @(negedge clk);
        end
        chk("t6_reach_bt", 32'(st_a), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_state", 32'(st_a), 32'd0);
        chk("t6_done", 32'(done_a), 32'd0);
        chk("t6_sat", 32'(rsat_a), 32'd0);
        chk("t6_code", 32'(rc_a), 32'd0);
        chk("t6_assigned", 32'(asg_a), 32'd0);
        chk("t6_values", 32'(val_a), 32'd0);
        chk("t6_cycles", cyc_a, 32'd0);
        chk("t6_conflicts", conf_a, 32'd0);
        chk("t6_b_code", 32'(rc_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 3, 0, "t6r");
        chk("t6r_code", 32'(rc_a), 32'd1);
        chk("t6r_values", 32'(val_a), 32'h2);
        chk("t6r_cycles", cyc_a, 32'd14);
        chk("t6r_conflicts", conf_a, 32'd1);
        run(1'b1, 2, 0, "t6b");
        chk("t6b_code", 32'(rc_b), 32'd2);
        chk("t6b_cycles", cyc_b, 32'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
